// File: rtl/tms1x00_core_if.sv
// Program-memory bus between the tms1x00 core (master) and its 1Kx8 instruction store (slave).
interface tms1x00_core_if;
  logic [9:0] rom_addr;
  logic [7:0] rom_data;

  modport master (
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    output rom_data
  );
endinterface

// File: rtl/tms1x00_core.sv
// TMS1000-compatible 4-bit core: two-clock FETCH/EXEC sequencer, 64x4 data RAM,
// R/O output latches and K inputs; instructions come from an external synchronous ROM.
module tms1x00_core #(
  parameter int unsigned RAM_WORDS = 64,
  parameter int unsigned R_BITS    = 11
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              run,
  tms1x00_core_if.master    rom,
  input  logic [3:0]        k_in,
  output logic [R_BITS-1:0] r_out,
  output logic [7:0]        o_out
);

  typedef enum logic {
    ST_FETCH,
    ST_EXEC
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        a_q, a_d;
  logic [1:0]        x_q, x_d;
  logic [3:0]        y_q, y_d;
  logic [5:0]        pc_q, pc_d;
  logic [3:0]        pa_q, pa_d;
  logic [3:0]        pb_q, pb_d;
  logic [5:0]        sr_q, sr_d;
  logic [3:0]        spa_q, spa_d;
  logic              s_q, s_d;
  logic              sl_q, sl_d;
  logic              cl_q, cl_d;
  logic [R_BITS-1:0] r_q, r_d;
  logic [7:0]        o_q, o_d;

  logic [3:0]        ram_q [RAM_WORDS];
  logic [5:0]        ram_addr;
  logic              ram_we;
  logic [3:0]        ram_wdata;

  logic [7:0]        op;
  logic [3:0]        n;
  logic [3:0]        m;
  logic [3:0]        bmask;
  logic [4:0]        sum5;

  assign op       = rom.rom_data;
  assign n        = op[3:0];
  assign ram_addr = {x_q, y_q};
  assign m        = ram_q[ram_addr];
  assign bmask    = 4'b0001 << op[1:0];

  assign rom.rom_addr = {pa_q, pc_q};
  assign r_out        = r_q;
  assign o_out        = o_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    x_d       = x_q;
    y_d       = y_q;
    pc_d      = pc_q;
    pa_d      = pa_q;
    pb_d      = pb_q;
    sr_d      = sr_q;
    spa_d     = spa_q;
    s_d       = s_q;
    sl_d      = sl_q;
    cl_d      = cl_q;
    r_d       = r_q;
    o_d       = o_q;
    ram_we    = 1'b0;
    ram_wdata = a_q;
    sum5      = '0;

    unique case (state_q)
      ST_FETCH: begin
        if (run) state_d = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        // Status defaults back to 1; only instructions that test or carry override it.
        s_d     = 1'b1;
        pc_d    = pc_q + 6'd1;

        case (op[7:4])
          4'h0: begin
            unique case (op[3:0])
              4'h0: x_d = x_q ^ 2'b11;
              4'h1: begin sum5 = {1'b0, a_q} + 5'd8;  a_d = sum5[3:0]; s_d = sum5[4]; end
              4'h2: begin s_d = (y_q != a_q); sl_d = (y_q != a_q); end
              4'h3: ram_we = 1'b1;
              4'h4: begin ram_we = 1'b1; a_d = '0; end
              4'h5: begin sum5 = {1'b0, a_q} + 5'd10; a_d = sum5[3:0]; s_d = sum5[4]; end
              4'h6: begin sum5 = {1'b0, a_q} + 5'd6;  a_d = sum5[3:0]; s_d = sum5[4]; end
              4'h7: begin a_d = a_q - 4'd1; s_d = (a_q != 4'd0); end
              4'h8: a_d = k_in;
              4'h9: s_d = (k_in != 4'd0);
              4'hA: o_d = {3'b000, sl_q, a_q};
              4'hB: o_d = '0;
              4'hC: if (32'(y_q) < R_BITS) r_d[y_q] = 1'b0;
              4'hD: if (32'(y_q) < R_BITS) r_d[y_q] = 1'b1;
              4'hE: a_d = a_q + 4'd1;
              4'hF: begin
                if (cl_q) begin
                  pc_d = sr_q;
                  pa_d = spa_q;
                  pb_d = spa_q;
                  cl_d = 1'b0;
                end
              end
            endcase
          end

          4'h1: pb_d = n;

          4'h2: begin
            unique case (op[3:0])
              4'h0: y_d = a_q;
              4'h1: a_d = m;
              4'h2: y_d = m;
              4'h3: a_d = y_q;
              4'h4: begin ram_we = 1'b1; y_d = y_q - 4'd1; s_d = (y_q != 4'd0); end
              4'h5: begin
                ram_we = 1'b1;
                sum5   = {1'b0, y_q} + 5'd1;
                y_d    = sum5[3:0];
                s_d    = sum5[4];
              end
              4'h6: begin a_d = m - 4'd1; s_d = (m != 4'd0); end
              4'h7: begin sum5 = {1'b0, m} + 5'd1; a_d = sum5[3:0]; s_d = sum5[4]; end
              4'h8, 4'h9, 4'hA, 4'hB: x_d = op[1:0];
              4'hC: begin a_d = 4'd0 - a_q; s_d = (a_q == 4'd0); end
              4'hD: a_d = '0;
              4'hE: s_d = (m != 4'd0);
              4'hF: begin sum5 = {1'b0, a_q} + {1'b0, m}; a_d = sum5[3:0]; s_d = sum5[4]; end
            endcase
          end

          4'h3: begin
            unique case (op[3:2])
              2'b00: begin ram_we = 1'b1; ram_wdata = m | bmask; end
              2'b01: begin ram_we = 1'b1; ram_wdata = m & ~bmask; end
              2'b10: s_d = |(m & bmask);
              2'b11: begin
                if (op[1:0] == 2'b00) begin
                  a_d = m - a_q;
                  s_d = (m >= a_q);
                end else if (op[1:0] == 2'b01) begin
                  s_d = (a_q <= m);
                end
              end
            endcase
          end

          4'h4: y_d = n;
          4'h5: s_d = (y_q != n);
          4'h6: begin ram_we = 1'b1; ram_wdata = n; y_d = y_q + 4'd1; end
          4'h7: s_d = (a_q <= n);

          default: begin
            // BR (op[6]=0) and CALL (op[6]=1); a CALL while already in a subroutine degrades to BR.
            if (s_q) begin
              pc_d = op[5:0];
              if (op[6] && !cl_q) begin
                sr_d  = pc_q + 6'd1;
                spa_d = pa_q;
                pa_d  = pb_q;
                cl_d  = 1'b1;
              end else if (!cl_q) begin
                pa_d = pb_q;
              end
            end
          end
        endcase
      end

      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_FETCH;
      a_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pc_q    <= '0;
      pa_q    <= '0;
      pb_q    <= '0;
      sr_q    <= '0;
      spa_q   <= '0;
      s_q     <= 1'b1;
      sl_q    <= 1'b0;
      cl_q    <= 1'b0;
      r_q     <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pc_q    <= pc_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      sr_q    <= sr_d;
      spa_q   <= spa_d;
      s_q     <= s_d;
      sl_q    <= sl_d;
      cl_q    <= cl_d;
      r_q     <= r_d;
      o_q     <= o_d;
    end
  end

  // RAM contents survive reset; a write is dropped while resetb is low.
  always_ff @(posedge clock) begin
    if (ram_we && resetb) ram_q[ram_addr] <= ram_wdata;
  end

endmodule

// File: tb/tb_tms1x00_core.sv
// Directed bench for tms1x00_core: each step places one opcode at the current fetch
// address of a synchronous ROM model, runs one instruction and checks the result.
module tb_tms1x00_core;
  logic        clock;
  logic        resetb;
  logic        run;
  logic [3:0]  k_in;
  logic [10:0] r_out;
  logic [7:0]  o_out;
  logic [7:0]  mem [1024];

  int unsigned n_cmp;
  int unsigned n_fail;

  tms1x00_core_if rom ();

  tms1x00_core #(.RAM_WORDS(64), .R_BITS(11)) dut (
    .clock  (clock),
    .resetb (resetb),
    .run    (run),
    .rom    (rom.master),
    .k_in   (k_in),
    .r_out  (r_out),
    .o_out  (o_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) rom.rom_data <= mem[rom.rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exec(input logic [7:0] opcode);
    mem[rom.rom_addr] = opcode;
    @(posedge clock);
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h3E;
    resetb = 1'b0;
    run    = 1'b0;
    k_in   = 4'h0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_rom_addr", 32'(rom.rom_addr), 32'h000);
    check("reset_r_out", 32'(r_out), 32'h000);
    check("reset_o_out", 32'(o_out), 32'h00);
    check("reset_s", 32'(dut.s_q), 32'h1);

    resetb = 1'b1;
    mem[0] = 8'h43;
    repeat (3) @(posedge clock);
    #1;
    check("hold_rom_addr", 32'(rom.rom_addr), 32'h000);
    check("hold_y", 32'(dut.y_q), 32'h0);
    run = 1'b1;

    exec(8'h43); exec(8'h0D);
    check("setr_r3", 32'(r_out), 32'h008);
    exec(8'h4A); exec(8'h0D); exec(8'h43); exec(8'h0C); exec(8'h4C); exec(8'h0D);
    check("r_out_pattern", 32'(r_out), 32'h400);

    exec(8'h45); exec(8'h23); exec(8'h0A);
    check("tdo", 32'(o_out), 32'h05);
    exec(8'h0B);
    check("clo", 32'(o_out), 32'h00);

    exec(8'h49); exec(8'h23); exec(8'h01);
    check("a8aac_a", 32'(dut.a_q), 32'h1);
    check("a8aac_s", 32'(dut.s_q), 32'h1);
    exec(8'h43); exec(8'h23); exec(8'h06);
    check("a6aac_a", 32'(dut.a_q), 32'h9);
    check("a6aac_s", 32'(dut.s_q), 32'h0);
    exec(8'h29); exec(8'h00);
    check("comx", 32'(dut.x_q), 32'h2);
    exec(8'h45); exec(8'h23); exec(8'h2C);
    check("cpaiz5_a", 32'(dut.a_q), 32'hB);
    check("cpaiz5_s", 32'(dut.s_q), 32'h0);
    exec(8'h2D); exec(8'h2C);
    check("cpaiz0_a", 32'(dut.a_q), 32'h0);
    check("cpaiz0_s", 32'(dut.s_q), 32'h1);

    k_in = 4'hA;
    exec(8'h08);
    check("tka", 32'(dut.a_q), 32'hA);
    k_in = 4'h0;
    exec(8'h09); exec(8'hA0);
    check("br_not_taken", 32'(rom.rom_addr), 32'h01C);
    k_in = 4'h3;
    exec(8'h09); exec(8'hB0);
    check("br_taken", 32'(rom.rom_addr), 32'h030);
    exec(8'h2D); exec(8'h07);
    check("dan_a", 32'(dut.a_q), 32'hF);
    check("dan_s", 32'(dut.s_q), 32'h0);
    exec(8'h4F); exec(8'h25);
    check("tamiyc_y", 32'(dut.y_q), 32'h0);
    check("tamiyc_s", 32'(dut.s_q), 32'h1);

    exec(8'h12); exec(8'hBF);
    check("br_page2", 32'(rom.rom_addr), 32'h0BF);
    exec(8'h3E);
    check("pc_wrap", 32'(rom.rom_addr), 32'h080);
    exec(8'h15); exec(8'hD0);
    check("call", 32'(rom.rom_addr), 32'h150);
    exec(8'h0F);
    check("retn", 32'(rom.rom_addr), 32'h082);

    exec(8'h47); exec(8'h23); exec(8'h40); exec(8'h03); exec(8'h0A);
    check("tdo7", 32'(o_out), 32'h07);
    exec(8'h2D);
    mem[rom.rom_addr] = 8'h03;
    @(posedge clock);
    #2 resetb = 1'b0;
    #1;
    check("midreset_rom_addr", 32'(rom.rom_addr), 32'h000);
    check("midreset_r_out", 32'(r_out), 32'h000);
    check("midreset_o_out", 32'(o_out), 32'h00);
    @(posedge clock);
    #1 resetb = 1'b1;
    check("restart_rom_addr", 32'(rom.rom_addr), 32'h000);

    exec(8'h2A); exec(8'h21);
    check("ram_kept", 32'(dut.a_q), 32'h7);
    exec(8'h27);
    check("imac_a", 32'(dut.a_q), 32'h8);
    check("imac_s", 32'(dut.s_q), 32'h0);
    exec(8'h77);
    check("alec", 32'(dut.s_q), 32'h0);
    exec(8'h3D);
    check("alem", 32'(dut.s_q), 32'h0);
    exec(8'h3C);
    check("saman_a", 32'(dut.a_q), 32'hF);
    check("saman_s", 32'(dut.s_q), 32'h0);
    exec(8'h02); exec(8'h0A);
    check("ynea_tdo_sl", 32'(o_out), 32'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end
endmodule
